// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Holds the FSM state encoding, default operand widths and the counter-width helper.
// No logic of its own; imported by seq_divider and div_step.
package seq_divider_pkg;

    // Divider control states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Default widths: a 5-bit dividend matches a 2x3 product
    localparam int DIV_DW_DEF = 5;
    localparam int DIV_VW_DEF = 3;

    // Step counter must hold values 0..DW
    function automatic int div_cnt_width(input int dw);
        return $clog2(dw + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor, restore on borrow.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to register the result.
module div_step
    import seq_divider_pkg::*;
#(
    parameter int VW = DIV_VW_DEF
) (
    input  logic [VW:0]   part,
    input  logic          din,
    input  logic [VW-1:0] divisor,
    output logic [VW:0]   part_nxt,
    output logic          qbit
);

    localparam int PW = VW + 1;

    // The partial is kept below the divisor between steps, so its top bit is
    // normally zero. It is still carried into the comparison so that a zero
    // divisor (where the partial simply accumulates dividend bits) always
    // reads as a non-negative trial and yields an all-ones quotient.
    logic [VW+1:0] shifted;
    logic [VW+1:0] dvsr_ext;

    assign shifted  = {part, din};
    assign dvsr_ext = {2'b00, divisor};

    // Trial subtraction: keep the difference when it does not borrow, else restore
    always_comb begin
        qbit     = (shifted >= dvsr_ext);
        part_nxt = shifted[VW:0];
        if (qbit) begin
            part_nxt = PW'(shifted - dvsr_ext);
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per clock; optional zero-divisor shortcut via SEQ_DIVIDER_DBZ_EN.
// Latency: DW+1 cycles from accepted start to the done pulse (1 cycle for a detected zero divisor).
// Backpressure: start is only sampled in IDLE; requests while busy are dropped, never queued.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int DW = DIV_DW_DEF,   // dividend / quotient width, must be >= VW and >= 2
    parameter int VW = DIV_VW_DEF    // divisor / remainder width
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          dbz
);

    localparam int             CW   = div_cnt_width(DW);
    localparam logic [CW-1:0]  LAST = CW'(DW - 1);

    div_state_t     state;
    div_state_t     state_nxt;

    logic [VW-1:0]  dvsr;       // divisor latched at acceptance
    logic [DW-1:0]  shreg;      // dividend bits leave the top, quotient bits enter the bottom
    logic [VW:0]    part;       // partial remainder
    logic [VW:0]    part_nxt;
    logic [CW-1:0]  cnt;        // steps completed in this operation
    logic           qbit;

    logic           accept;
    logic           zero_div;
    logic           last_step;

    assign accept    = (state == IDLE) && start;
    assign last_step = (state == RUN) && (cnt == LAST);

`ifdef SEQ_DIVIDER_DBZ_EN
    assign zero_div = (divisor == '0);
`else
    assign zero_div = 1'b0;
`endif

    div_step #(
        .VW       (VW)
    ) u_step (
        .part     (part),
        .din      (shreg[DW-1]),
        .divisor  (dvsr),
        .part_nxt (part_nxt),
        .qbit     (qbit)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: a detected zero divisor skips the RUN phase entirely
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = zero_div ? DONE : RUN;
                end
            end
            RUN: begin
                if (cnt == LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs decoded from the state
    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Working registers: load on acceptance, advance one restoring step per RUN cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dvsr  <= '0;
            shreg <= '0;
            part  <= '0;
            cnt   <= '0;
        end else if (accept) begin
            dvsr  <= divisor;
            shreg <= dividend;
            part  <= '0;
            cnt   <= '0;
        end else if (state == RUN) begin
            part  <= part_nxt;
            shreg <= {shreg[DW-2:0], qbit};
            cnt   <= cnt + CW'(1);
        end
    end

    // Result registers: written only on completion so they hold steady between operations
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quotient  <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
        end else if (last_step) begin
            quotient  <= {shreg[DW-2:0], qbit};
            remainder <= part_nxt[VW-1:0];
            dbz       <= 1'b0;
        end else if (accept && zero_div) begin
            quotient  <= '1;
            remainder <= dividend[VW-1:0];
            dbz       <= 1'b1;
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider against an arithmetic reference model.
// Directed cases, ignored/held start, mid-run reset, exhaustive sweep and random operations.
// Build with SEQ_DIVIDER_DBZ_EN defined or not; the model follows the same macro.
module tb_seq_divider;

    localparam int DW = 5;
    localparam int VW = 3;

`ifdef SEQ_DIVIDER_DBZ_EN
    localparam bit DBZ_EN = 1'b1;
`else
    localparam bit DBZ_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] dividend = '0;
    logic [VW-1:0] divisor = '0;
    logic          busy;
    logic          done;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          dbz;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    seq_divider #(
        .DW        (DW),
        .VW        (VW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference behaviour straight from the arithmetic definition
    task automatic model(input int a, input int b, output int q, output int r,
                         output int d, output int lat);
        if (b == 0) begin
            q   = (1 << DW) - 1;
            r   = a % (1 << VW);
            d   = DBZ_EN ? 1 : 0;
            lat = DBZ_EN ? 1 : DW + 1;
        end else begin
            q   = a / b;
            r   = a % b;
            d   = 0;
            lat = DW + 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one division, optionally poking a second start at observation poke_k
    task automatic run_op(input int a, input int b, input int poke_k, input string tag);
        int q, r, d, lat, k, busy_bad;
        bit got;
        model(a, b, q, r, d, lat);
        start    = 1'b1;
        dividend = DW'(a);
        divisor  = VW'(b);
        tick();
        start    = 1'b0;
        k        = 1;
        got      = 1'b0;
        busy_bad = 0;
        while (!got && k <= 3 * DW) begin
            if (busy !== 1'b1) busy_bad++;
            if (done === 1'b1) begin
                got = 1'b1;
            end else begin
                if (k == poke_k) begin
                    start    = 1'b1;
                    dividend = DW'(9);
                    divisor  = VW'(2);
                end
                tick();
                start = 1'b0;
                k++;
            end
        end
        chk({tag, " latency"}, got ? k : -1, lat);
        chk({tag, " busy"}, busy_bad, 0);
        chk({tag, " quotient"}, quotient, q);
        chk({tag, " remainder"}, remainder, r);
        chk({tag, " dbz"}, dbz, d);
        if (b != 0) begin
            chk({tag, " identity"}, int'(quotient) * b + int'(remainder), a);
            chk({tag, " rem<div"}, int'(remainder) < b, 1);
        end
        tick();
        chk({tag, " done pulse"}, done, 0);
        chk({tag, " idle"}, busy, 0);
    endtask

    initial begin
        int d1, d2, q, r, d, lat, gap, a, b;

        // Reset state
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst quotient", quotient, 0);
        chk("rst remainder", remainder, 0);
        chk("rst dbz", dbz, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Directed operations
        run_op(21, 3, 0, "21/3");
        run_op(31, 7, 0, "31/7");
        run_op(31, 1, 0, "31/1");
        run_op(0, 5, 0, "0/5");
        run_op(13, 0, 0, "13/0");

        // Start pulsed while busy must be dropped
        run_op(21, 3, 2, "21/3 ignore");

        // Start held high: back-to-back operations DW+2 cycles apart
        start    = 1'b1;
        dividend = DW'(21);
        divisor  = VW'(3);
        d1 = -1;
        d2 = -1;
        for (int i = 0; i < 30 && d2 < 0; i++) begin
            tick();
            if (done === 1'b1) begin
                if (d1 < 0) d1 = cyc;
                else begin
                    d2    = cyc;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        chk("held interval", d2 - d1, DW + 2);
        chk("held quotient", quotient, 7);
        chk("held remainder", remainder, 0);
        tick();
        chk("held idle", busy, 0);

        // Asynchronous reset in the middle of RUN
        start    = 1'b1;
        dividend = DW'(21);
        divisor  = VW'(3);
        tick();
        start = 1'b0;
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst busy", busy, 0);
        chk("arst done", done, 0);
        chk("arst quotient", quotient, 0);
        chk("arst remainder", remainder, 0);
        chk("arst dbz", dbz, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post-rst idle", busy, 0);
        run_op(6, 4, 0, "6/4");

        // Exhaustive operand sweep
        for (int sa = 0; sa < (1 << DW); sa++) begin
            for (int sb = 0; sb < (1 << VW); sb++) begin
                run_op(sa, sb, 0, $sformatf("sweep %0d/%0d", sa, sb));
            end
        end

        // Random operations with idle gaps; results must hold between operations
        repeat (40) begin
            a = int'($urandom_range(0, (1 << DW) - 1));
            b = int'($urandom_range(0, (1 << VW) - 1));
            run_op(a, b, 0, $sformatf("rand %0d/%0d", a, b));
            model(a, b, q, r, d, lat);
            gap = int'($urandom_range(0, 3));
            repeat (gap) tick();
            chk("rand hold quotient", quotient, q);
            chk("rand hold remainder", remainder, r);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #1000000;
        $display("FAIL watchdog expired after %0d cycles", cyc);
        $fatal(1, "watchdog");
    end

endmodule
